// File: rtl/cmda_dly_pkg.sv
// Shared constants and types for the CMD/address lane delay sequencer.
package cmda_dly_pkg;

    // Default number of CMD/address output lanes in the PHY.
    localparam int NUM_CMDA_LANES = 32;

    // Width of one lane delay value; bits [2:0] are the fine delay.
    localparam int DLY_W = 8;

    // Sequencer states.
    //   IDLE : waiting for a request (new or pending)
    //   SCAN : one lane per cycle, strobing the dirty ones
    //   LOAD : waiting for the command sequencer to go quiet, then load
    //   DONE : one-cycle tail before returning to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cmda_dly_shadow.sv
// Shadow register file of per-lane delays with a dirty bit per lane.
// One write port, one read port (lane idx) and one clear-dirty port.
// A write and a clear on the same lane in the same cycle: the write wins,
// so the lane stays dirty and holds the newly written value.
module cmda_dly_shadow
    import cmda_dly_pkg::*;
#(
    parameter int NUM_LANES = NUM_CMDA_LANES,
    parameter int LANE_AW   = 5
) (
    input  logic               clk_div,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [LANE_AW-1:0] wr_addr,
    input  logic [DLY_W-1:0]   wr_data,
    input  logic [LANE_AW-1:0] rd_idx,
    output logic [DLY_W-1:0]   rd_data,
    output logic               rd_dirty,
    input  logic               clr_en,
    input  logic [LANE_AW-1:0] clr_idx
);

    // Lane count expressed one bit wider than an index so the range
    // compare below is free of width surprises.
    localparam logic [LANE_AW:0] LANE_LIMIT = (LANE_AW + 1)'(NUM_LANES);

    logic [DLY_W-1:0]     mem [NUM_LANES];
    logic [NUM_LANES-1:0] dirty;
    logic                 wr_ok;
    logic                 clr_ok;
    logic                 rd_ok;

    // Addresses at or beyond the lane count are silently dropped.
    always_comb begin
        wr_ok  = wr_en  && ({1'b0, wr_addr} < LANE_LIMIT);
        clr_ok = clr_en && ({1'b0, clr_idx} < LANE_LIMIT);
        rd_ok  = ({1'b0, rd_idx} < LANE_LIMIT);
    end

    // Delay storage and dirty tracking; write is ordered after clear so it wins.
    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                mem[i] <= '0;
            end
            dirty <= '0;
        end else begin
            if (clr_ok) begin
                dirty[clr_idx] <= 1'b0;
            end
            if (wr_ok) begin
                mem[wr_addr]   <= wr_data;
                dirty[wr_addr] <= 1'b1;
            end
        end
    end

    // Read port: current stored value and dirty flag of the addressed lane.
    always_comb begin
        rd_data  = '0;
        rd_dirty = 1'b0;
        if (rd_ok) begin
            rd_data  = mem[rd_idx];
            rd_dirty = dirty[rd_idx];
        end
    end

endmodule

// File: rtl/cmda_dly_seq.sv
// CMD/address lane delay sequencer. On an apply request it walks every
// lane in index order, strobes each dirty lane's shadow value onto the
// shared dly_data bus with a one-hot set_delay, then issues a single
// broadcast ld_delay once the command sequencer is idle.
//
// Handshake: apply_req is sampled every cycle. In IDLE it starts an apply
// immediately; in any other state it sets a one-deep pending flag which
// is consumed on the IDLE cycle that follows DONE. apply_busy is high from
// the first SCAN cycle to the end of DONE; apply_done pulses exactly once
// per apply, in the same cycle as ld_delay (ld_delay only when at least
// one lane was strobed).
module cmda_dly_seq
    import cmda_dly_pkg::*;
#(
    parameter int NUM_LANES = NUM_CMDA_LANES,
    parameter int LANE_AW   = 5
) (
    input  logic                 clk_div,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [LANE_AW-1:0]   wr_addr,
    input  logic [DLY_W-1:0]     wr_data,
    input  logic                 apply_req,
    input  logic                 cmd_active,
    output logic                 apply_busy,
    output logic                 apply_done,
    output logic [DLY_W-1:0]     dly_data,
    output logic [NUM_LANES-1:0] set_delay,
    output logic                 ld_delay,
    output logic [1:0]           dbg_state
);

    localparam logic [LANE_AW-1:0]   LAST_IDX = LANE_AW'(NUM_LANES - 1);
    localparam logic [NUM_LANES-1:0] ONE_HOT0 = NUM_LANES'(1);

    state_t               state_q;
    state_t               state_d;
    logic [LANE_AW-1:0]   idx_q;
    logic [LANE_AW-1:0]   idx_d;
    logic                 any_set_q;
    logic                 any_set_d;
    logic                 pend_q;
    logic                 pend_d;

    logic [DLY_W-1:0]     dly_data_d;
    logic [NUM_LANES-1:0] set_delay_d;
    logic                 ld_delay_d;
    logic                 apply_done_d;

    logic [DLY_W-1:0]     sh_rd_data;
    logic                 sh_rd_dirty;
    logic                 sh_clr_en;

    cmda_dly_shadow #(
        .NUM_LANES (NUM_LANES),
        .LANE_AW   (LANE_AW)
    ) u_shadow (
        .clk_div  (clk_div),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_idx   (idx_q),
        .rd_data  (sh_rd_data),
        .rd_dirty (sh_rd_dirty),
        .clr_en   (sh_clr_en),
        .clr_idx  (idx_q)
    );

    // State, scan index, bookkeeping flags and all registered outputs.
    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            any_set_q  <= 1'b0;
            pend_q     <= 1'b0;
            dly_data   <= '0;
            set_delay  <= '0;
            ld_delay   <= 1'b0;
            apply_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            any_set_q  <= any_set_d;
            pend_q     <= pend_d;
            dly_data   <= dly_data_d;
            set_delay  <= set_delay_d;
            ld_delay   <= ld_delay_d;
            apply_done <= apply_done_d;
        end
    end

    // Next-state logic: scan walk, load gating on cmd_active, pending merge.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        any_set_d    = any_set_q;
        pend_d       = pend_q;
        dly_data_d   = dly_data;
        set_delay_d  = '0;
        ld_delay_d   = 1'b0;
        apply_done_d = 1'b0;
        sh_clr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (apply_req || pend_q) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    any_set_d = 1'b0;
                    pend_d    = 1'b0;
                end
            end

            SCAN: begin
                // The strobe carries the value stored before this edge; a
                // colliding write lands in the shadow and keeps the lane dirty.
                if (sh_rd_dirty) begin
                    dly_data_d  = sh_rd_data;
                    set_delay_d = ONE_HOT0 << idx_q;
                    sh_clr_en   = 1'b1;
                    any_set_d   = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = LOAD;
                end else begin
                    idx_d = idx_q + LANE_AW'(1);
                end
            end

            LOAD: begin
                // Never change lane delays under a live command.
                if (!cmd_active) begin
                    ld_delay_d   = any_set_q;
                    apply_done_d = 1'b1;
                    state_d      = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Requests arriving while busy collapse into one pending apply.
        if ((state_q != IDLE) && apply_req) begin
            pend_d = 1'b1;
        end
    end

    // Busy covers SCAN, LOAD and DONE.
    always_comb begin
        apply_busy = (state_q != IDLE);
        dbg_state  = state_q;
    end

endmodule
